// File: rtl/prog_pkg.sv
// Shared constants and types for the RAT MCU program-address generator.
// Holds the next-PC selection encoding used by the priority resolver.
package prog_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam logic [DEF_ADDR_W-1:0] DEF_INTR_VEC = 10'h3FF;

    typedef logic [DEF_ADDR_W-1:0] pc_addr_t;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_IMMED,
        SEL_STACK,
        SEL_VEC,
        SEL_ZERO
    } pc_sel_e;

endpackage

// File: rtl/prog_counter_if.sv
// Command and status bundle between the control unit and the PC block.
// master = control unit, slave = program counter.
interface prog_counter_if #(
    parameter int ADDR_W      = 10,
    parameter int STACK_DEPTH = 8
);
    localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

    logic              PC_INC;
    logic              PC_JMP;
    logic              PC_CALL;
    logic              PC_RET;
    logic              PC_INTR;
    logic [ADDR_W-1:0] FROM_IMMED;
    logic [ADDR_W-1:0] PC_COUNT;
    logic [LVL_W-1:0]  STACK_LVL;
    logic              STACK_EMPTY;
    logic              STACK_FULL;
    logic              STACK_ERR;

    modport master (
        output PC_INC, PC_JMP, PC_CALL, PC_RET, PC_INTR, FROM_IMMED,
        input  PC_COUNT, STACK_LVL, STACK_EMPTY, STACK_FULL, STACK_ERR
    );

    modport slave (
        input  PC_INC, PC_JMP, PC_CALL, PC_RET, PC_INTR, FROM_IMMED,
        output PC_COUNT, STACK_LVL, STACK_EMPTY, STACK_FULL, STACK_ERR
    );

endinterface

// File: rtl/ret_stack.sv
// Hardware return-address LIFO with full/empty guards.
// err pulses for one cycle on a dropped push or an empty pop.
module ret_stack #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] pop_data,
    output logic [LVL_W-1:0]  lvl,
    output logic              empty,
    output logic              full,
    output logic              err
);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              do_push;
    logic              do_pop;

    assign empty   = (lvl == '0);
    assign full    = (lvl == LVL_W'(DEPTH));
    assign wr_idx  = lvl[IDX_W-1:0];
    assign rd_idx  = wr_idx - IDX_W'(1);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~push & ~empty;
    assign pop_data = mem[rd_idx];
    assign err     = (push & full) | (pop & ~push & empty);

    // Occupancy counter: up on accepted push, down on accepted pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl <= '0;
        end else if (do_push) begin
            lvl <= lvl + LVL_W'(1);
        end else if (do_pop) begin
            lvl <= lvl - LVL_W'(1);
        end
    end

    // Entry storage; contents need no reset since the level gates reads.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Program counter for the RAT MCU fetch path: priority resolver,
// next-PC mux, PC register and sticky stack-error flag.
module prog_counter #(
    parameter int ADDR_W      = prog_pkg::DEF_ADDR_W,
    parameter int STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] INTR_VEC = prog_pkg::DEF_INTR_VEC
) (
    input logic         CLK,
    input logic         RST,
    prog_counter_if.slave bus
);
    import prog_pkg::*;

    localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

    pc_sel_e           sel;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] push_data;
    logic [ADDR_W-1:0] pop_data;
    logic [LVL_W-1:0]  lvl;
    logic              st_empty;
    logic              st_full;
    logic              st_err;
    logic              err_q;

    assign pc_inc    = pc_q + ADDR_W'(1);
    assign push_data = bus.PC_INTR ? pc_q : pc_inc;

    // Priority resolver: one command wins, the rest have no effect.
    always_comb begin
        sel  = SEL_HOLD;
        push = 1'b0;
        pop  = 1'b0;
        if (bus.PC_INTR) begin
            sel  = SEL_VEC;
            push = 1'b1;
        end else if (bus.PC_RET) begin
            pop = 1'b1;
            sel = st_empty ? SEL_ZERO : SEL_STACK;
        end else if (bus.PC_CALL) begin
            sel  = SEL_IMMED;
            push = 1'b1;
        end else if (bus.PC_JMP) begin
            sel = SEL_IMMED;
        end else if (bus.PC_INC) begin
            sel = SEL_INC;
        end
    end

    // Next-PC mux driven by the resolved selection.
    always_comb begin
        pc_d = pc_q;
        unique case (sel)
            SEL_HOLD:  pc_d = pc_q;
            SEL_INC:   pc_d = pc_inc;
            SEL_IMMED: pc_d = bus.FROM_IMMED;
            SEL_STACK: pc_d = pop_data;
            SEL_VEC:   pc_d = INTR_VEC;
            SEL_ZERO:  pc_d = '0;
            default:   pc_d = pc_q;
        endcase
    end

    // PC register feeding the ROM address.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Sticky error: any dropped push or empty pop until reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (st_err) begin
            err_q <= 1'b1;
        end
    end

    ret_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .pop_data  (pop_data),
        .lvl       (lvl),
        .empty     (st_empty),
        .full      (st_full),
        .err       (st_err)
    );

    assign bus.PC_COUNT    = pc_q;
    assign bus.STACK_LVL   = lvl;
    assign bus.STACK_EMPTY = st_empty;
    assign bus.STACK_FULL  = st_full;
    assign bus.STACK_ERR   = err_q;

endmodule

// File: doc/prog_counter.md
# prog_counter

Program-address generator for the RAT MCU fetch path. It holds the 10-bit program counter and drives the program ROM's address input directly. It also resolves next-address selection for increment, jump, call, return and interrupt, and keeps an internal hardware return-address stack. The control unit issues one command per cycle; the ROM returns the instruction one clock after each new address.

## Interface
Parameters:
- ADDR_W, 10, program address width; must match the ROM depth of 1024 words.
- STACK_DEPTH, 8, number of return-address entries; power of two, at least 2.
- INTR_VEC, 10'h3FF, interrupt vector address.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- PC_INC  in  1  advance to PC_COUNT+1.
- PC_JMP  in  1  load FROM_IMMED.
- PC_CALL  in  1  push PC_COUNT+1, load FROM_IMMED.
- PC_RET  in  1  pop the top of stack into PC_COUNT.
- PC_INTR  in  1  push PC_COUNT, load INTR_VEC.
- FROM_IMMED  in  ADDR_W  jump/call target from the instruction field.
- PC_COUNT  out  ADDR_W  registered program counter; connects to the ROM address.
- STACK_LVL  out  $clog2(STACK_DEPTH)+1  number of occupied stack entries.
- STACK_EMPTY  out  1  STACK_LVL==0.
- STACK_FULL  out  1  STACK_LVL==STACK_DEPTH.
- STACK_ERR  out  1  sticky overflow/underflow flag.

## Operation
- Reset values:
  - PC_COUNT=0, STACK_LVL=0, STACK_EMPTY=1, STACK_FULL=0, STACK_ERR=0.
  - Stack contents are don't-care.
- Command priority, highest first: RST > PC_INTR > PC_RET > PC_CALL > PC_JMP > PC_INC > hold.
  - Exactly one command takes effect per cycle; lower-priority commands asserted in the same cycle are ignored, with no side effects.
- Increment arithmetic is modulo 2^ADDR_W: 0x3FF+1 wraps to 0x000. The value pushed by CALL wraps the same way.
- CALL, not full: write PC_COUNT+1 to stack[STACK_LVL], increment STACK_LVL, set PC_COUNT=FROM_IMMED.
- INTR, not full: same as CALL, except the pushed value is PC_COUNT and the target is INTR_VEC.
- CALL/INTR, full: the push is dropped and the stack is unchanged. PC_COUNT still loads the target. STACK_ERR is set.
- RET, not empty: PC_COUNT=stack[STACK_LVL-1], then decrement STACK_LVL.
- RET, empty: PC_COUNT=0, STACK_LVL stays 0, STACK_ERR is set.
- STACK_ERR clears only on RST.
- Hold (no command): all state is unchanged.
- The stack is strictly LIFO. Entries above STACK_LVL are never read.

## Timing
- Command sampled at edge N appears on PC_COUNT after edge N, so one-cycle latency.
- The ROM registers its output, so the instruction for that address is valid after edge N+1. The control unit must account for this two-stage fetch.
- STACK_LVL, STACK_EMPTY, STACK_FULL and STACK_ERR are all registered and update on the same edge as PC_COUNT.
- A RET in the cycle right after a CALL returns the just-pushed value: the stack write is visible to the next cycle.
- RST asserted mid-sequence (for example one cycle after a CALL) discards all stack state on that edge. Outputs show reset values after that edge.
- No combinational path exists from any input to any output.

## Structure
- Package prog_pkg:
  - ADDR_W default and INTR_VEC constants.
  - Typedef pc_addr_t = logic [ADDR_W-1:0].
  - Enum pc_sel_e {SEL_HOLD, SEL_INC, SEL_IMMED, SEL_STACK, SEL_VEC, SEL_ZERO}, the encoding of the priority resolver's output.
- Sub-module ret_stack holds the LIFO:
  - Array, level counter, push/pop with full/empty guards.
  - Returns a dropped-push / empty-pop error pulse.
- prog_counter contains the priority resolver, the next-PC mux and the PC register, and latches ret_stack's error pulse into STACK_ERR.

## Test plan
- Reset, then 3 cycles of PC_INC: PC_COUNT goes 0,1,2,3. With PC_COUNT=0x3FF, PC_INC gives 0x000.
- At PC_COUNT=0x010, PC_CALL with FROM_IMMED=0x100 gives PC_COUNT=0x100 and STACK_LVL=1. A following PC_RET gives PC_COUNT=0x011 and STACK_LVL=0.
- At PC_COUNT=0x020, PC_INTR gives PC_COUNT=0x3FF. PC_RET then gives 0x020.
- Overflow: 8 CALLs, then a 9th CALL to 0x055. Required: PC_COUNT=0x055, STACK_LVL=8, STACK_ERR=1. Eight RETs then return the pushed addresses in reverse order.
- Underflow: PC_RET on an empty stack gives PC_COUNT=0 and STACK_ERR=1; STACK_ERR stays 1 until RST.
- Priority: PC_INTR, PC_CALL, PC_JMP and PC_INC all asserted together push only once and load 0x3FF. Asserting RST together with PC_CALL gives all reset values.
